// File: rtl/mem_pkg.sv
// Shared definitions for the pipeline memory stage: bus widths,
// through-field bit positions, access size codes and FSM states.
package mem_pkg;

    localparam int EXE_MEM_W = 110;
    localparam int MEM_WB_W  = 102;

    localparam int T_MEM_EN  = 15;
    localparam int T_MEM_WE  = 14;
    localparam int T_SIZE_HI = 13;
    localparam int T_SIZE_LO = 12;
    localparam int T_SEXT    = 11;
    localparam int T_WB_EN   = 10;
    localparam int T_DEST_HI = 9;
    localparam int T_DEST_LO = 5;
    localparam int T_RSVD    = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for data memory: store strobes/replicated data and
// load lane extraction with sign/zero extension. Purely combinational.
// Ports: size/off/sext select the access; sdata/rdata in; wstrb/wdata/ldata out.
module mem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sext,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb    = 8'(rdata >> {off, 3'b000});
        lh    = off[1] ? rdata[31:16] : rdata[15:0];
        wstrb = 4'b1111;
        wdata = sdata;
        ldata = rdata;
        unique case (size)
            SZ_B: begin
                wstrb = 4'b0001 << off;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sext & lb[7]}}, lb};
            end
            SZ_H: begin
                wstrb = 4'b0011 << {off[1], 1'b0};
                wdata = {2{sdata[15:0]}};
                ldata = {{16{sext & lh[15]}}, lh};
            end
            SZ_W, 2'b11: begin
                wstrb = 4'b1111;
                wdata = sdata;
                ldata = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs loads/stores over req/gnt/rvalid and
// registers the result into MEM_WB_BUS with a valid/allow-in handshake.
// Ports: EXE_MEM_BUS/exe_valid/mem_allow_in from execute;
// MEM_WB_BUS/mem_wb_valid/wb_allow_in to writeback; dm_* data memory.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word raise exc
// instead of being masked to natural alignment.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int THROUGH_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_BUS,
    input  logic                 exe_valid,
    output logic                 mem_allow_in,
    output logic [MEM_WB_W-1:0]  MEM_WB_BUS,
    output logic                 mem_wb_valid,
    input  logic                 wb_allow_in,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_gnt,
    input  logic                 dm_rvalid,
    input  logic [31:0]          dm_rdata
);

    localparam logic [31:0] AMASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                  : ((32'd1 << ADDR_W) - 32'd1);

    logic [THROUGH_W-1:0] in_thr;
    logic [31:0]          in_alu;
    logic [31:0]          in_out;
    logic [29:0]          in_pc;
    logic [1:0]           in_size;
    logic                 in_mis;
    logic                 go_mem;
    logic                 acc;

    state_t state, nxt;

    logic        we_r, sext_r, wb_en_r, rsvd_r, exc_r;
    logic [1:0]  size_r;
    logic [4:0]  dest_r;
    logic [31:0] alu_r, out_r, result, badv_r;
    logic [29:0] pc_r;
    logic [31:0] eaddr;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, lane_ldata;
    logic        unused_ok;

    assign {in_thr, in_alu, in_out, in_pc} = EXE_MEM_BUS;
    assign in_size   = in_thr[T_SIZE_HI:T_SIZE_LO];
    assign unused_ok = ^{in_thr[4:1]};

`ifdef MEM_ALIGN_CHECK_EN
    assign in_mis = in_thr[T_MEM_EN]
                  & (((in_size == SZ_H) & in_alu[0])
                  |  (in_size[1] & (|in_alu[1:0])));
    assign eaddr  = alu_r & AMASK;
`else
    assign in_mis = 1'b0;
    // Misaligned accesses silently drop the low bits.
    always_comb begin
        eaddr = alu_r & AMASK;
        unique case (size_r)
            SZ_B:    ;
            SZ_H:    eaddr[0] = 1'b0;
            default: eaddr[1:0] = 2'b00;
        endcase
    end
`endif

    assign go_mem = in_thr[T_MEM_EN] & ~in_mis;
    assign acc    = exe_valid & mem_allow_in;

    mem_lane u_lane (
        .size  (size_r),
        .off   (eaddr[1:0]),
        .sext  (sext_r),
        .sdata (out_r),
        .rdata (dm_rdata),
        .wstrb (lane_wstrb),
        .wdata (lane_wdata),
        .ldata (lane_ldata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (acc) nxt = go_mem ? S_REQ : S_DONE;
            S_REQ:  if (dm_gnt) nxt = we_r ? S_DONE : S_WAIT;
            S_WAIT: if (dm_rvalid) nxt = S_DONE;
            S_DONE: begin
                if (wb_allow_in) begin
                    if (acc) nxt = go_mem ? S_REQ : S_DONE;
                    else     nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_allow_in = (state == S_IDLE)
                     | ((state == S_DONE) & wb_allow_in);
        mem_wb_valid = (state == S_DONE);
        dm_req       = (state == S_REQ);
        dm_we        = dm_req & we_r;
        dm_wstrb     = dm_req ? lane_wstrb : 4'b0000;
        dm_addr      = dm_req ? {eaddr[31:2], 2'b00} : 32'h0;
        dm_wdata     = dm_req ? lane_wdata : 32'h0;
    end

    // Result defaults to out_data at accept; only a load overwrites it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_r    <= 1'b0;
            sext_r  <= 1'b0;
            size_r  <= 2'b00;
            wb_en_r <= 1'b0;
            dest_r  <= 5'd0;
            rsvd_r  <= 1'b0;
            alu_r   <= 32'h0;
            out_r   <= 32'h0;
            pc_r    <= 30'h0;
            result  <= 32'h0;
            exc_r   <= 1'b0;
            badv_r  <= 32'h0;
        end else if (acc) begin
            we_r    <= in_thr[T_MEM_WE];
            sext_r  <= in_thr[T_SEXT];
            size_r  <= in_size;
            wb_en_r <= in_thr[T_WB_EN] & ~in_mis
                     & ~(in_thr[T_MEM_EN] & in_thr[T_MEM_WE]);
            dest_r  <= in_thr[T_DEST_HI:T_DEST_LO];
            rsvd_r  <= in_thr[T_RSVD];
            alu_r   <= in_alu;
            out_r   <= in_out;
            pc_r    <= in_pc;
            result  <= in_out;
            exc_r   <= in_mis;
            badv_r  <= in_mis ? in_alu : 32'h0;
        end else if ((state == S_WAIT) && dm_rvalid) begin
            result  <= lane_ldata;
        end
    end

    assign MEM_WB_BUS = {wb_en_r, dest_r, result, exc_r,
                         badv_r, pc_r, rsvd_r};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: vector table of single transactions
// plus hand sequences for backpressure and reset corner cases.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic [109:0] bus;
    logic         exe_valid;
    logic         mem_allow_in;
    logic [101:0] MEM_WB_BUS;
    logic         mem_wb_valid;
    logic         wb_allow_in;
    logic         dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_addr, dm_wdata, dm_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_MEM_BUS  (bus),
        .exe_valid    (exe_valid),
        .mem_allow_in (mem_allow_in),
        .MEM_WB_BUS   (MEM_WB_BUS),
        .mem_wb_valid (mem_wb_valid),
        .wb_allow_in  (wb_allow_in),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_wstrb     (dm_wstrb),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata)
    );

    typedef struct {
        logic [15:0] thr;
        logic [31:0] alu;
        logic [31:0] out;
        logic [31:0] rdata;
        logic [29:0] pc;
        int          gdly;
        int          lat;
        logic [31:0] res;
        logic        wb_en;
        logic        exc;
        logic [31:0] badv;
        logic        req;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [101:0] act,
                       input logic [101:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // lat = clock edges after the accept edge until mem_wb_valid.
    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        int    nreq;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        bus       = {v.thr, v.alu, v.out, v.pc};
        exe_valid = 1'b1;
        @(negedge clk);
        exe_valid = 1'b0;
        bus       = '0;
        cyc       = 0;
        nreq      = 0;
        while (!mem_wb_valid && cyc < 20) begin
            dm_gnt    = 1'b0;
            dm_rvalid = 1'b0;
            dm_rdata  = 32'h0;
            if (dm_req) begin
                nreq++;
                chk({t, "_we"},    dm_we,    v.thr[14]);
                chk({t, "_addr"},  dm_addr,  v.addr);
                chk({t, "_wstrb"}, dm_wstrb, v.wstrb);
                chk({t, "_wdata"}, dm_wdata, v.wdata);
                if (nreq > v.gdly) dm_gnt = 1'b1;
            end else if (nreq > 0) begin
                dm_rvalid = 1'b1;
                dm_rdata  = v.rdata;
            end
            @(negedge clk);
            cyc++;
        end
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        chk({t, "_valid"}, mem_wb_valid, 1'b1);
        chk({t, "_lat"},   cyc, v.lat);
        chk({t, "_nreq"},  nreq, v.req ? v.gdly + 1 : 0);
        chk({t, "_wb_en"}, MEM_WB_BUS[101], v.wb_en);
        chk({t, "_dest"},  MEM_WB_BUS[100:96], v.thr[9:5]);
        chk({t, "_res"},   MEM_WB_BUS[95:64], v.res);
        chk({t, "_exc"},   MEM_WB_BUS[63], v.exc);
        chk({t, "_badv"},  MEM_WB_BUS[62:31], v.badv);
        chk({t, "_pc"},    MEM_WB_BUS[30:1], v.pc);
        chk({t, "_rsvd"},  MEM_WB_BUS[0], v.thr[0]);
        wb_allow_in = 1'b1;
        @(negedge clk);
        wb_allow_in = 1'b0;
        chk({t, "_idle_valid"}, mem_wb_valid, 1'b0);
        chk({t, "_idle_allow"}, mem_allow_in, 1'b1);
    endtask

    task automatic accept(input logic [109:0] b);
        @(negedge clk);
        bus       = b;
        exe_valid = 1'b1;
        @(negedge clk);
        exe_valid = 1'b0;
    endtask

    logic [101:0] bp_exp;
    logic [101:0] b2b_exp;

    initial begin
        vt[0] = '{16'h0420, 32'h0, 32'h12345678, 32'h0, 30'h100, 0, 0,
                  32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0};
        vt[1] = '{16'hC440, 32'h1003, 32'h000000AB, 32'h0, 30'h101, 2, 3,
                  32'h000000AB, 1'b0, 1'b0, 32'h0, 1'b1, 4'h8, 32'hABABABAB,
                  32'h1000};
        vt[2] = '{16'h9C60, 32'h2002, 32'h0, 32'h80010000, 30'h102, 0, 2,
                  32'hFFFF8001, 1'b1, 1'b0, 32'h0, 1'b1, 4'hC, 32'h0, 32'h2000};
        vt[3] = '{16'h9460, 32'h2002, 32'h0, 32'h80010000, 30'h103, 1, 3,
                  32'h00008001, 1'b1, 1'b0, 32'h0, 1'b1, 4'hC, 32'h0, 32'h2000};
        vt[4] = '{16'h8C80, 32'h2001, 32'h0, 32'h0000F000, 30'h104, 0, 2,
                  32'hFFFFFFF0, 1'b1, 1'b0, 32'h0, 1'b1, 4'h2, 32'h0, 32'h2000};
        vt[5] = '{16'hA4A0, 32'h4000, 32'h0, 32'hDEADBEEF, 30'h105, 0, 2,
                  32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h4000};
        vt[6] = '{16'hD000, 32'h1002, 32'h1234CAFE, 32'h0, 30'h106, 1, 2,
                  32'h1234CAFE, 1'b0, 1'b0, 32'h0, 1'b1, 4'hC, 32'hCAFECAFE,
                  32'h1000};
        vt[7] = '{16'hF001, 32'h1008, 32'h55AA55AA, 32'h0, 30'h107, 0, 1,
                  32'h55AA55AA, 1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h55AA55AA,
                  32'h1008};
`ifdef MEM_ALIGN_CHECK_EN
        vt[8] = '{16'hA4C0, 32'h3002, 32'h0, 32'h11223344, 30'h108, 0, 0,
                  32'h0, 1'b0, 1'b1, 32'h3002, 1'b0, 4'h0, 32'h0, 32'h0};
`else
        vt[8] = '{16'hA4C0, 32'h3002, 32'h0, 32'h11223344, 30'h108, 0, 2,
                  32'h11223344, 1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0,
                  32'h3000};
`endif
        bp_exp  = {1'b1, 5'd1, 32'h12345678, 1'b0, 32'h0, 30'h200, 1'b0};
        b2b_exp = {1'b1, 5'd2, 32'h0BADF00D, 1'b0, 32'h0, 30'h201, 1'b0};

        resetn      = 1'b0;
        bus         = '0;
        exe_valid   = 1'b0;
        wb_allow_in = 1'b0;
        dm_gnt      = 1'b0;
        dm_rvalid   = 1'b0;
        dm_rdata    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", mem_wb_valid, 1'b0);
        chk("rst_req",   dm_req, 1'b0);
        chk("rst_we",    dm_we, 1'b0);
        chk("rst_wstrb", dm_wstrb, 4'h0);
        chk("rst_addr",  dm_addr, 32'h0);
        chk("rst_wdata", dm_wdata, 32'h0);
        chk("rst_bus",   MEM_WB_BUS, 102'h0);
        chk("rst_allow", mem_allow_in, 1'b1);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Backpressure, then back-to-back accept on release.
        accept({16'h0420, 32'h0, 32'h12345678, 30'h200});
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", mem_wb_valid, 1'b1);
            chk("bp_allow", mem_allow_in, 1'b0);
            chk("bp_bus",   MEM_WB_BUS, bp_exp);
            @(negedge clk);
        end
        bus         = {16'h0440, 32'h0, 32'h0BADF00D, 30'h201};
        exe_valid   = 1'b1;
        wb_allow_in = 1'b1;
        #1;
        chk("b2b_allow", mem_allow_in, 1'b1);
        @(negedge clk);
        exe_valid   = 1'b0;
        wb_allow_in = 1'b0;
        chk("b2b_valid", mem_wb_valid, 1'b1);
        chk("b2b_bus",   MEM_WB_BUS, b2b_exp);
        wb_allow_in = 1'b1;
        @(negedge clk);
        wb_allow_in = 1'b0;
        chk("b2b_idle", mem_wb_valid, 1'b0);

        // Reset while the request is outstanding.
        accept({16'hA4A0, 32'h4000, 32'h0, 30'h300});
        chk("rreq_pre", dm_req, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rreq_req",   dm_req, 1'b0);
        chk("rreq_valid", mem_wb_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Reset while waiting for rvalid, then a stale rvalid in IDLE.
        accept({16'hA4A0, 32'h4000, 32'h0, 30'h301});
        chk("rwait_req", dm_req, 1'b1);
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("rwait_pre_req",   dm_req, 1'b0);
        chk("rwait_pre_valid", mem_wb_valid, 1'b0);
        resetn = 1'b0;
        #1;
        chk("rwait_valid", mem_wb_valid, 1'b0);
        chk("rwait_dmreq", dm_req, 1'b0);
        chk("rwait_allow", mem_allow_in, 1'b1);
        @(negedge clk);
        resetn    = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk("stale_valid", mem_wb_valid, 1'b0);
        chk("stale_bus",   MEM_WB_BUS, 102'h0);
        chk("stale_req",   dm_req, 1'b0);

        // Reset while holding a result for writeback.
        accept({16'h0420, 32'h0, 32'h77777777, 30'h302});
        chk("rdone_pre", mem_wb_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rdone_valid", mem_wb_valid, 1'b0);
        chk("rdone_bus",   MEM_WB_BUS, 102'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage CPU pipeline; consumes the 110-bit EXE_MEM_BUS produced by the execute stage.
- Performs data-memory loads and stores over a req/gnt/rvalid interface, with byte/half/word sizing and sign/zero extension.
- Registers the result into MEM_WB_BUS with a valid/allow-in handshake toward writeback.
- Non-memory ops pass through with one cycle of latency.

Parameters:
- ADDR_W, 32, data-memory byte-address width (alu_data[ADDR_W-1:0] used).
- THROUGH_W, 16, width of the control field forwarded from decode.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- EXE_MEM_BUS  input  110  {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}.
- exe_valid  input  1  EXE_MEM_BUS holds a valid instruction this cycle.
- mem_allow_in  output  1  stage can accept EXE_MEM_BUS this cycle.
- MEM_WB_BUS  output  102  {wb_en, wb_dest[4:0], result[31:0], exc, badvaddr[31:0], pc[29:0], rsvd[0]}.
- mem_wb_valid  output  1  MEM_WB_BUS valid.
- wb_allow_in  input  1  writeback accepts MEM_WB_BUS this cycle.
- dm_req  output  1  memory request.
- dm_we  output  1  1 = store.
- dm_wstrb  output  4  byte enables.
- dm_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- dm_wdata  output  32  lane-shifted store data.
- dm_gnt  input  1  request accepted this cycle.
- dm_rvalid  input  1  load data valid.
- dm_rdata  input  32  load data, word-aligned.

Behaviour:
- through decode:
  - [15] mem_en, [14] mem_we, [13:12] size (00 B, 01 H, 10 W, 11 treated as W), [11] load sign-extend, [10] wb_en, [9:5] wb_dest, [4:0] reserved (bit 0 forwarded).
- Address = alu_data; store data = out_data.
- Reset: state IDLE; mem_wb_valid=0, dm_req=0, dm_we=0, dm_wstrb=0, dm_addr=0, dm_wdata=0, MEM_WB_BUS=0.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_allow_in=1. Acceptance = exe_valid & mem_allow_in; latches the bus.
  - !mem_en -> DONE; result=out_data.
  - mem_en -> REQ, dm_req asserted from the next edge.
- REQ:
  - dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata held stable until dm_gnt.
  - On gnt, store -> DONE (result=out_data, wb_en forced 0).
  - On gnt, load -> WAIT.
- WAIT: on dm_rvalid, extract the lane by addr[1:0], extend per bit 11, then go to DONE.
- DONE:
  - mem_wb_valid=1; bus held stable until wb_allow_in.
  - wb_allow_in & exe_valid in the same cycle: accept the new instruction (DONE->REQ/DONE) with no bubble.
  - wb_allow_in alone: go to IDLE.
- mem_allow_in = IDLE | (DONE & wb_allow_in).
- Latency, accept to mem_wb_valid:
  - non-mem: 1 cycle.
  - store: 1 + gnt-wait cycles.
  - load: 2 + gnt-wait + rvalid-wait cycles.
- Lanes:
  - byte wstrb = 0001<<addr[1:0], data replicated ×4.
  - half wstrb = 0011<<{addr[1],0}, data replicated ×2.
  - word wstrb = 1111.
- dm_rvalid outside WAIT is ignored. Memory shares resetn, so no transaction survives reset.
- Reset asserted mid-operation (any state) drops dm_req and mem_wb_valid asynchronously and discards the in-flight instruction.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - half with addr[0]!=0, or word with addr[1:0]!=0: no memory request is issued; goes IDLE->DONE.
  - Output exc=1, badvaddr=alu_data, wb_en=0.
- Undefined:
  - low address bits are masked to natural alignment (half: addr[0]=0; word: addr[1:0]=0).
  - exc is tied 0; badvaddr is tied 0.

Decomposition:
- Package mem_pkg holds:
  - bus widths (EXE_MEM_W=110, MEM_WB_W=102).
  - through field bit positions.
  - size codes SZ_B/SZ_H/SZ_W.
  - FSM state enum.
- Sub-module mem_lane (combinational) holds store strobe/data alignment and load lane extraction plus sign/zero extension. It is reused by both the REQ and WAIT paths.

Test Plan:
- Non-mem op: through=0x0420 (wb_en, dest=1), out_data=0x12345678 -> mem_wb_valid one cycle later, result=0x12345678, wb_en=1, dest=1.
- Store byte: addr=0x1003, data=0x000000AB, gnt delayed 2 cycles -> dm_req held 3 cycles, wstrb=1000, wdata=0xABABABAB, dm_addr=0x1000; then DONE with wb_en=0.
- Load half signed: addr=0x2002, rdata=0x80010000 -> result=0xFFFF8001. Same load unsigned -> result=0x00008001.
- Backpressure and back-to-back: wb_allow_in=0 for 3 cycles -> MEM_WB_BUS stable, mem_allow_in=0. Release with exe_valid=1 -> next instruction accepted the same cycle, no bubble.
- Reset mid-WAIT: resetn low while awaiting rvalid -> dm_req=0 and mem_wb_valid=0 immediately; after release, a stale rvalid in IDLE has no effect.
- MEM_ALIGN_CHECK_EN: word load at addr=0x3002 -> no dm_req; exc=1, badvaddr=0x00003002, wb_en=0. Without the macro -> dm_addr=0x3000, normal load.
